i2c_target_rx: RTL and testbench
================================

// Module: i2c_target_rx
// PURPOSE
//  I2C target (slave) write receiver: the bus responder paired with the master-side START/STOP/bit
//  generators. Samples raw SDA/SCL, detects START/STOP, matches a 7-bit address, ACKs matching write
//  transfers and emits each received data byte as a one-cycle strobe. SDA is open-drain: drive 0 = pull low, 1 = release.
// PARAMETERS
//  TARGET_ADDR  7'h33  7-bit address this target responds to
//  SYNC_STAGES  2      flop stages on i_sda/i_scl before edge detection (>=2)
// PORTS
//  i_clk         in   1  system clock; SCL must be <= i_clk/8
//  i_rst         in   1  synchronous, active-high reset
//  i_sda         in   1  raw SDA pin level (asynchronous)
//  i_scl         in   1  raw SCL pin level (asynchronous)
//  o_sda_drive   out  1  0 = pull SDA low (ACK), 1 = release
//  o_data        out  8  last received data byte, MSB first on the bus; held until next byte
//  o_valid       out  1  1-cycle pulse: o_data updated
//  o_start       out  1  1-cycle pulse: START or repeated START detected
//  o_stop        out  1  1-cycle pulse: STOP detected
//  o_busy        out  1  1 from START until STOP (bus owned by some master)
//  o_selected    out  1  1 while in an addressed write transfer (ADDR_ACK..DATA_ACK)
// BEHAVIOUR
//  - Reset: o_sda_drive=1, o_data=0, o_valid/o_start/o_stop=0, o_busy=0, o_selected=0, state IDLE,
//    bit counter 0, sync flops and edge-history preset to 1 (idle bus: no false edge after reset).
//  - Sync: SYNC_STAGES flops, then one history flop; events decoded on synced vs history values.
//    Raw pin edge -> event pulse latency = SYNC_STAGES+1 cycles.
//  - START: scl_s=1 and sda_s 1->0. STOP: scl_s=1 and sda_s 0->1. Bit sample: scl_s 0->1. Drive change: scl_s 1->0.
//  - START/STOP take priority over every state; same-cycle SDA and SCL edges: condition check uses scl_s history (=1).
//  - States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
//    IDLE: wait START -> ADDR.
//    ADDR: shift 8 bits on SCL rises (7 addr + R/W). After 8th rise: addr==TARGET_ADDR and R/W=0 -> ADDR_ACK;
//      otherwise -> IGNORE (no ACK; read requests are NACKed).
//    ADDR_ACK: on next SCL fall drive o_sda_drive=0; on the following SCL fall (end of 9th clock)
//      release to 1 -> DATA, bit counter 0.
//    DATA: shift 8 bits; on 8th rise load o_data, pulse o_valid next cycle -> DATA_ACK.
//    DATA_ACK: same ACK timing as ADDR_ACK -> DATA.
//    IGNORE: SDA released; ignore SCL until START/STOP.
//  - START in any state (repeated START): o_start pulse, release SDA, clear counter/shift reg -> ADDR.
//  - STOP in any state: o_stop pulse, release SDA, o_busy=0 -> IDLE; partial byte discarded, no o_valid.
//  - o_busy set on START, cleared on STOP or reset. o_selected=1 in ADDR_ACK, DATA, DATA_ACK.
//  - Bit counter 4 bits, 0..8, never wraps; SCL rises beyond 8 while awaiting ACK fall are ignored.
//  - No backpressure: consumer must take o_data within one byte time (>= 9 SCL periods).
//  - SCL is never driven (no clock stretching).
// TESTING
//  1. START, 0x66 (addr 0x33,W), data 0xA5, 0x3C, STOP -> ACK low on 3 ninth clocks; o_valid x2 with 0xA5 then 0x3C; o_start/o_stop one pulse each.
//  2. START, 0x68 (addr 0x34,W), 0xFF, STOP -> o_sda_drive stays 1 throughout; no o_valid; o_busy 1 until STOP.
//  3. START, 0x67 (addr 0x33,R) -> no ACK, state IGNORE, o_selected=0; STOP -> IDLE.
//  4. START, 0x66, 0x12, repeated START, 0x66, 0x34, STOP -> o_start x2, o_valid x2 (0x12, 0x34), o_busy continuous.
//  5. START, 0x66, 4 bits of data, STOP -> o_stop pulse, no o_valid, SDA released, IDLE.
//  6. i_rst asserted while o_sda_drive=0 in DATA_ACK -> o_sda_drive=1 next cycle, all outputs reset; no spurious o_start after release.

Source files
------------

// File: rtl/i2c_target_rx.sv
// I2C target write receiver.
// It samples raw SDA/SCL, decodes START/STOP and bit edges, and matches a 7-bit address.
// It ACKs write transfers addressed to TARGET_ADDR and emits each received data byte as a one-cycle strobe.
// SDA is open-drain: o_sda_drive=0 pulls the line low, 1 releases it.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h33,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sda,
  input  logic       i_scl,
  output logic       o_sda_drive,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_busy,
  output logic       o_selected
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sdaSync;
  logic [SYNC_STAGES-1:0] r_sclSync;
  logic                   r_sdaHist;
  logic                   r_sclHist;

  state_t     r_state;
  logic [3:0] r_bitCnt;
  logic [6:0] r_shift;
  logic       r_sdaDrive;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_start;
  logic       r_stop;
  logic       r_busy;

  state_t     w_stateNext;
  logic [3:0] w_bitCntNext;
  logic [6:0] w_shiftNext;
  logic       w_driveNext;
  logic [7:0] w_dataNext;
  logic       w_validNext;
  logic       w_startNext;
  logic       w_stopNext;
  logic       w_busyNext;

  logic       w_sdaS;
  logic       w_sclS;
  logic       w_startCond;
  logic       w_stopCond;
  logic       w_sclRise;
  logic       w_sclFall;
  logic [7:0] w_byteIn;

  // Synchronise the pins and keep one history sample; preset high so an idle bus shows no edge after reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sdaSync <= '1;
      r_sclSync <= '1;
      r_sdaHist <= 1'b1;
      r_sclHist <= 1'b1;
    end else begin
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], i_sda};
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], i_scl};
      r_sdaHist <= w_sdaS;
      r_sclHist <= w_sclS;
    end
  end

  assign w_sdaS = r_sdaSync[SYNC_STAGES-1];
  assign w_sclS = r_sclSync[SYNC_STAGES-1];

  // Bus conditions qualify on the SCL history, so a same-cycle SCL fall still counts as SCL high
  assign w_startCond = r_sclHist & r_sdaHist & ~w_sdaS;
  assign w_stopCond  = r_sclHist & ~r_sdaHist & w_sdaS;
  assign w_sclRise   = ~r_sclHist & w_sclS;
  assign w_sclFall   = r_sclHist & ~w_sclS;
  assign w_byteIn    = {r_shift, w_sdaS};

  // Register the FSM state together with the datapath and the output pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bitCnt   <= 4'd0;
      r_shift    <= 7'd0;
      r_sdaDrive <= 1'b1;
      r_data     <= 8'd0;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_bitCnt   <= w_bitCntNext;
      r_shift    <= w_shiftNext;
      r_sdaDrive <= w_driveNext;
      r_data     <= w_dataNext;
      r_valid    <= w_validNext;
      r_start    <= w_startNext;
      r_stop     <= w_stopNext;
      r_busy     <= w_busyNext;
    end
  end

  // Next-state and output decode; a bus condition overrides whatever the current state is doing
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_driveNext  = r_sdaDrive;
    w_dataNext   = r_data;
    w_validNext  = 1'b0;
    w_startNext  = 1'b0;
    w_stopNext   = 1'b0;
    w_busyNext   = r_busy;
    if (w_startCond) begin
      w_stateNext  = S_ADDR;
      w_bitCntNext = 4'd0;
      w_shiftNext  = 7'd0;
      w_driveNext  = 1'b1;
      w_startNext  = 1'b1;
      w_busyNext   = 1'b1;
    end else if (w_stopCond) begin
      w_stateNext  = S_IDLE;
      w_bitCntNext = 4'd0;
      w_shiftNext  = 7'd0;
      w_driveNext  = 1'b1;
      w_stopNext   = 1'b1;
      w_busyNext   = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_sclRise) begin
            w_shiftNext = w_byteIn[6:0];
            if (r_bitCnt == 4'd7) begin
              w_bitCntNext = 4'd8;
              if ((w_byteIn[7:1] == TARGET_ADDR) && !w_byteIn[0]) begin
                w_stateNext = S_ADDR_ACK;
              end else begin
                w_stateNext = S_IGNORE;
              end
            end else begin
              w_bitCntNext = r_bitCnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_sclRise) begin
            w_shiftNext = w_byteIn[6:0];
            if (r_bitCnt == 4'd7) begin
              w_bitCntNext = 4'd8;
              w_dataNext   = w_byteIn;
              w_validNext  = 1'b1;
              w_stateNext  = S_DATA_ACK;
            end else begin
              w_bitCntNext = r_bitCnt + 4'd1;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: begin
          if (w_sclFall) begin
            if (r_sdaDrive) begin
              w_driveNext = 1'b0;
            end else begin
              w_driveNext  = 1'b1;
              w_stateNext  = S_DATA;
              w_bitCntNext = 4'd0;
              w_shiftNext  = 7'd0;
            end
          end
        end
        default: begin
          w_driveNext = 1'b1;
        end
      endcase
    end
  end

  assign o_sda_drive = r_sdaDrive;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_start     = r_start;
  assign o_stop      = r_stop;
  assign o_busy      = r_busy;
  assign o_selected  = (r_state == S_ADDR_ACK) || (r_state == S_DATA) || (r_state == S_DATA_ACK);

endmodule

// File: tb/tb_i2c_target_rx.sv
// Scoreboard testbench for i2c_target_rx.
// A bit-banged master drives the bus and a transaction-level model predicts ACKs and received bytes.
// A monitor process pops expected bytes on each o_valid and counts START/STOP pulses.
module tb_i2c_target_rx;

  localparam logic [6:0] TARGET = 7'h33;
  localparam int         Q      = 5;

  logic       i_clk;
  logic       i_rst;
  logic       tbSda;
  logic       tbScl;
  logic       sdaBus;
  logic       o_sda_drive;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_start;
  logic       o_stop;
  logic       o_busy;
  logic       o_selected;

  int         compareCount;
  int         failCount;
  int         startSeen;
  int         stopSeen;
  int         expStarts;
  int         expStops;
  bit         modelSel;
  logic [7:0] expQ[$];

  // The wired-AND bus: the master and the target can each pull SDA low
  assign sdaBus = tbSda & o_sda_drive;

  i2c_target_rx #(.TARGET_ADDR(TARGET), .SYNC_STAGES(2)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_sda      (sdaBus),
    .i_scl      (tbScl),
    .o_sda_drive(o_sda_drive),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_start    (o_start),
    .o_stop     (o_stop),
    .o_busy     (o_busy),
    .o_selected (o_selected)
  );

  // System clock with a 10 ns period
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Abort if the run overruns its time budget
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%02h, required 0x%02h", name, actual, expected);
    end
  endtask

  // Each o_valid pops one expected byte, and START/STOP pulses are tallied
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_start) startSeen++;
      if (o_stop) stopSeen++;
      if (o_valid) begin
        if (expQ.size() == 0) begin
          compareCount++;
          failCount++;
          $display("[TB] FAIL valid_unexpected: got data 0x%02h, required no o_valid", o_data);
        end else begin
          checkOutput("valid_data", o_data, expQ.pop_front());
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic sendBit(input logic b);
    tbSda = b;
    waitCycles(Q);
    tbScl = 1'b1;
    waitCycles(2 * Q);
    tbScl = 1'b0;
    waitCycles(Q);
  endtask

  task automatic sendBits(input logic [7:0] value, input int n);
    for (int i = 0; i < n; i++) sendBit(value[7-i]);
  endtask

  task automatic sendStart();
    expStarts++;
    modelSel = 1'b0;
    tbSda = 1'b0;
    waitCycles(Q);
    tbScl = 1'b0;
    waitCycles(Q);
    checkOutput("busy_after_start", o_busy, 1'b1);
  endtask

  task automatic sendRepStart();
    expStarts++;
    modelSel = 1'b0;
    tbSda = 1'b1;
    waitCycles(Q);
    tbScl = 1'b1;
    waitCycles(Q);
    tbSda = 1'b0;
    waitCycles(Q);
    tbScl = 1'b0;
    waitCycles(Q);
    checkOutput("busy_after_rstart", o_busy, 1'b1);
  endtask

  task automatic sendStop();
    expStops++;
    modelSel = 1'b0;
    tbSda = 1'b0;
    waitCycles(Q);
    tbScl = 1'b1;
    waitCycles(Q);
    tbSda = 1'b1;
    waitCycles(2 * Q);
    checkOutput("busy_after_stop", o_busy, 1'b0);
    checkOutput("sel_after_stop", o_selected, 1'b0);
    checkOutput("drive_after_stop", o_sda_drive, 1'b1);
  endtask

  // Transaction-level model: the first byte after a START is the address; later bytes land only when selected
  task automatic modelByte(input logic [7:0] v, input bit isAddr, output logic expAck);
    if (isAddr) begin
      modelSel = (v[7:1] == TARGET) && !v[0];
    end else if (modelSel) begin
      expQ.push_back(v);
    end
    expAck = modelSel;
  endtask

  task automatic ackClock(input logic expAck);
    logic ackSeen;
    tbSda = 1'b1;
    waitCycles(Q);
    tbScl = 1'b1;
    waitCycles(Q);
    ackSeen = ~sdaBus;
    checkOutput("ack_level", ackSeen, expAck);
    waitCycles(Q);
    tbScl = 1'b0;
    waitCycles(Q);
  endtask

  task automatic sendByte(input logic [7:0] v, input bit isAddr);
    logic expAck;
    modelByte(v, isAddr, expAck);
    sendBits(v, 8);
    ackClock(expAck);
    if (isAddr) checkOutput("selected_after_addr", o_selected, modelSel);
  endtask

  // One random transfer: an address, up to three data bytes, an optional short partial byte, then STOP or a held bus
  task automatic applyStimulus(input bit useRepStart, output bit stopped);
    logic [7:0] addr;
    int         pick;
    int         nData;
    if (useRepStart) sendRepStart();
    else sendStart();
    pick = $urandom_range(0, 3);
    case (pick)
      0: addr = 8'h66;
      1: addr = 8'h67;
      2: addr = 8'h68;
      default: addr = 8'($urandom);
    endcase
    sendByte(addr, 1'b1);
    nData = $urandom_range(0, 3);
    for (int i = 0; i < nData; i++) sendByte(8'($urandom), 1'b0);
    if ($urandom_range(0, 3) == 0) sendBits(8'($urandom), $urandom_range(1, 6));
    if ($urandom_range(0, 2) == 0) begin
      stopped = 1'b0;
    end else begin
      sendStop();
      stopped = 1'b1;
    end
  endtask

  initial begin
    bit         stopped;
    int         startsBefore;
    logic       expAck;

    compareCount = 0;
    failCount    = 0;
    startSeen    = 0;
    stopSeen     = 0;
    expStarts    = 0;
    expStops     = 0;
    modelSel     = 1'b0;
    tbSda        = 1'b1;
    tbScl        = 1'b1;
    i_rst        = 1'b1;
    waitCycles(3);
    checkOutput("reset_drive", o_sda_drive, 1'b1);
    checkOutput("reset_data", o_data, 8'h00);
    checkOutput("reset_valid", o_valid, 1'b0);
    checkOutput("reset_busy", o_busy, 1'b0);
    checkOutput("reset_selected", o_selected, 1'b0);
    i_rst = 1'b0;
    waitCycles(5);
    checkOutput("idle_start", o_start, 1'b0);

    $display("[TB] directed: addressed write of two bytes");
    sendStart();
    sendByte(8'h66, 1'b1);
    sendByte(8'hA5, 1'b0);
    sendByte(8'h3C, 1'b0);
    sendStop();

    $display("[TB] directed: other address");
    sendStart();
    sendByte(8'h68, 1'b1);
    sendByte(8'hFF, 1'b0);
    checkOutput("busy_mid_foreign", o_busy, 1'b1);
    sendStop();

    $display("[TB] directed: read request is not acknowledged");
    sendStart();
    sendByte(8'h67, 1'b1);
    sendStop();

    $display("[TB] directed: repeated START");
    sendStart();
    sendByte(8'h66, 1'b1);
    sendByte(8'h12, 1'b0);
    sendRepStart();
    sendByte(8'h66, 1'b1);
    sendByte(8'h34, 1'b0);
    sendStop();

    $display("[TB] directed: partial byte before STOP");
    sendStart();
    sendByte(8'h66, 1'b1);
    sendBits(8'hB0, 4);
    sendStop();

    $display("[TB] directed: reset during the data ACK");
    sendStart();
    sendByte(8'h66, 1'b1);
    modelByte(8'h5A, 1'b0, expAck);
    sendBits(8'h5A, 8);
    checkOutput("drive_in_data_ack", o_sda_drive, expAck ? 1'b0 : 1'b1);
    tbSda = 1'b1;
    i_rst = 1'b1;
    waitCycles(1);
    checkOutput("rst_drive", o_sda_drive, 1'b1);
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_selected", o_selected, 1'b0);
    checkOutput("rst_data", o_data, 8'h00);
    waitCycles(3);
    startsBefore = startSeen;
    i_rst = 1'b0;
    modelSel = 1'b0;
    waitCycles(2 * Q);
    tbScl = 1'b1;
    waitCycles(4 * Q);
    checkOutput("no_start_after_rst", 8'(startSeen - startsBefore), 8'd0);

    $display("[TB] random transfers");
    stopped = 1'b1;
    for (int t = 0; t < 20; t++) applyStimulus(!stopped, stopped);
    if (!stopped) sendStop();

    waitCycles(20);
    checkOutput("start_pulses", 8'(startSeen), 8'(expStarts));
    checkOutput("stop_pulses", 8'(stopSeen), 8'(expStops));
    checkOutput("bytes_outstanding", 8'(expQ.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
